// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the fetch front end: FSM state encodings, the jump opcode
// and the default reset PC.
package inst_fetch_unit_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam logic [5:0]  OPC_J            = 6'b000010;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  function automatic logic is_jump_op(input logic [5:0] opcode);
    return opcode == OPC_J;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_pc_next_calc.sv
// Combinational next-PC logic: sequential, PC-relative branch and absolute jump targets.
// All arithmetic wraps modulo 2^ADDR_W.
module pc_next_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jidx26,
  input  logic              nPC_sel,
  input  logic              is_j,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] br_off;

  assign pc_plus4 = pc + ADDR_W'(4);
  assign br_off   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

  // A jump wins over a taken branch
  always_comb begin
    next_pc = pc_plus4;
    if (is_j) begin
      next_pc = {pc_plus4[ADDR_W-1:28], jidx26, 2'b00};
    end else if (nPC_sel) begin
      next_pc = pc_plus4 + br_off;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, req/ack fetch from imem, instruction latch.
// Optional JUMP_EN macro adds the absolute j (opcode 000010) target.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              ex_done,
  input  logic              nPC_sel,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       instr_reg;
  logic [ADDR_W-1:0] next_pc;
  logic              is_j;

`ifdef JUMP_EN
  assign is_j = is_jump_op(instr_reg[31:26]);
`else
  assign is_j = 1'b0;
`endif

  pc_next_calc #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_calc (
    .pc      (pc_reg),
    .imm16   (instr_reg[15:0]),
    .jidx26  (instr_reg[25:0]),
    .nPC_sel (nPC_sel),
    .is_j    (is_j),
    .pc_plus4(pc_plus4),
    .next_pc (next_pc)
  );

  // Outputs decode straight from state so an async reset drops the request at once
  assign imem_req    = (state_reg == S_FETCH);
  assign imem_addr   = imem_req ? pc_reg : '0;
  assign instr_valid = (state_reg == S_EXEC);
  assign instr       = instr_reg;
  assign pc          = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_reg <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_reg <= imem_rdata;
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ex_done) begin
            pc_reg    <= next_pc;
            state_reg <= S_FETCH;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: the driver pushes expected fetch addresses and
// executed instructions, a monitor pops and compares on each new request / valid rise.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req, imem_ack, instr_valid, ex_done, nPC_sel;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;

  logic        w_req, w_ack, w_valid, w_ex_done, w_sel;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc_plus4;

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .ex_done(ex_done), .nPC_sel(nPC_sel),
    .pc(pc), .pc_plus4(pc_plus4)
  );

  // Second instance starts at the top of the address space to exercise wrap-around
  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) wrap_dut (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .instr(w_instr),
    .instr_valid(w_valid), .ex_done(w_ex_done), .nPC_sel(w_sel),
    .pc(w_pc), .pc_plus4(w_pc_plus4)
  );

`ifdef JUMP_EN
  localparam logic [31:0] J1_NEXT = 32'h0040_0100;
  localparam logic [31:0] J2_PC   = 32'h0040_0100;
  localparam logic [31:0] J2_NEXT = 32'h0040_0100;
`else
  localparam logic [31:0] J1_NEXT = 32'h0040_000C;
  localparam logic [31:0] J2_PC   = 32'h0040_000C;
  localparam logic [31:0] J2_NEXT = 32'h0040_0110;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_exec_t;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] exp_addr_q[$];
  exp_exec_t   exp_exec_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: got timeout/unexpected event expected DUT response", name);
  endtask

  // Monitor: one fetch-address check per new request, one instr/pc check per valid rise
  initial begin
    logic      prev_req;
    logic      prev_valid;
    logic [31:0] ea;
    exp_exec_t ee;
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_fetch");
        else begin
          ea = exp_addr_q.pop_front();
          check("fetch_addr", imem_addr, ea);
          $display("fetch  addr=0x%08h expected=0x%08h", imem_addr, ea);
        end
      end
      if (instr_valid && !prev_valid) begin
        if (exp_exec_q.size() == 0) fail_now("unexpected_valid");
        else begin
          ee = exp_exec_q.pop_front();
          check("exec_instr", instr, ee.instr);
          check("exec_pc", pc, ee.pc);
          check("exec_pc_plus4", pc_plus4, ee.pc + 32'd4);
          $display("exec   pc=0x%08h instr=0x%08h", pc, instr);
        end
      end
      prev_req   = imem_req;
      prev_valid = instr_valid;
    end
  end

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = imem_req;
    if (!ok) fail_now("req_timeout");
  endtask

  task automatic run_instr(input logic [31:0] rdata, input int wait_cyc, input int hold_cyc,
                           input logic sel, input logic [31:0] this_pc,
                           input logic [31:0] exp_next);
    bit ok;
    int n;
    wait_req(ok);
    if (!ok) return;
    exp_exec_q.push_back('{rdata, this_pc});
    // ex_done and nPC_sel are noise while fetching
    ex_done = (wait_cyc > 0);
    nPC_sel = 1'b1;
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check("req_held", 32'(imem_req), 32'd1);
    end
    ex_done    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      fail_now("valid_timeout");
      return;
    end
    // Stray acks during execute must not disturb the latched instruction
    for (int i = 0; i < hold_cyc; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("instr_stable", instr, rdata);
      check("pc_stable", pc, this_pc);
    end
    imem_ack = 1'b0;
    ex_done  = 1'b1;
    nPC_sel  = sel;
    exp_addr_q.push_back(exp_next);
    @(posedge clk);
    #1;
    ex_done = 1'b0;
    nPC_sel = ~sel;
  endtask

  initial begin
    bit ok;
    imem_ack = 1'b0; imem_rdata = '0; ex_done = 1'b0; nPC_sel = 1'b0;
    w_ack = 1'b0; w_rdata = '0; w_ex_done = 1'b0; w_sel = 1'b0;
    exp_addr_q.push_back(32'h0040_0000);
    #12;
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_req", 32'(imem_req), 32'd0);

    run_instr(32'h2108_0001, 3, 2, 1'b0, 32'h0040_0000, 32'h0040_0004);
    run_instr(32'h0000_0000, 0, 0, 1'b0, 32'h0040_0004, 32'h0040_0008);
    run_instr(32'h1000_0000, 1, 0, 1'b1, 32'h0040_0008, 32'h0040_000C);
    run_instr(32'h0000_0000, 0, 1, 1'b0, 32'h0040_000C, 32'h0040_0010);
    run_instr(32'h1000_FFFF, 0, 0, 1'b1, 32'h0040_0010, 32'h0040_0010);
    run_instr(32'h1000_0003, 2, 0, 1'b1, 32'h0040_0010, 32'h0040_0020);
    run_instr(32'h1000_FFF8, 0, 0, 1'b1, 32'h0040_0020, 32'h0040_0004);
    run_instr(32'h0000_0000, 0, 0, 1'b0, 32'h0040_0004, 32'h0040_0008);
    run_instr(32'h0810_0040, 0, 0, 1'b0, 32'h0040_0008, J1_NEXT);
    run_instr(32'h0810_0040, 0, 0, 1'b1, J2_PC, J2_NEXT);

    // Async reset while fetching
    wait_req(ok);
    exp_addr_q.push_back(32'h0040_0000);
    #2 rst = 1'b1;
    #1;
    check("arst_fetch_req", 32'(imem_req), 32'd0);
    check("arst_fetch_addr", imem_addr, 32'd0);
    check("arst_fetch_pc", pc, 32'h0040_0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Async reset while executing with ex_done pending
    wait_req(ok);
    exp_exec_q.push_back('{32'h1000_0003, 32'h0040_0000});
    imem_ack = 1'b1;
    imem_rdata = 32'h1000_0003;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
    exp_addr_q.push_back(32'h0040_0000);
    ex_done = 1'b1;
    nPC_sel = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_exec_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    check("arst_exec_pc", pc, 32'h0040_0000);
    ex_done = 1'b0;
    rst = 1'b0;
    run_instr(32'h0000_0000, 0, 0, 1'b0, 32'h0040_0000, 32'h0040_0004);

    // Wrap-around on the second instance
    @(negedge clk);
    check("wrap_req", 32'(w_req), 32'd1);
    check("wrap_addr", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1;
    w_rdata = 32'h1000_0005;
    @(posedge clk);
    #1 w_ack = 1'b0;
    @(negedge clk);
    check("wrap_valid", 32'(w_valid), 32'd1);
    check("wrap_instr", w_instr, 32'h1000_0005);
    check("wrap_pc_plus4", w_pc_plus4, 32'h0000_0000);
    w_ex_done = 1'b1;
    w_sel = 1'b0;
    @(posedge clk);
    #1 w_ex_done = 1'b0;
    @(negedge clk);
    check("wrap_next_req", 32'(w_req), 32'd1);
    check("wrap_next_addr", w_addr, 32'h0000_0000);
    check("wrap_next_pc", w_pc, 32'h0000_0000);
    $display("wrap   pc=0x%08h addr=0x%08h", w_pc, w_addr);

    @(negedge clk);
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("exec_q_drained", 32'(exp_exec_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
